// File: rtl/boid_pixel_writer.sv
`default_nettype none
// ============================================================================
// Module      : boid_pixel_writer
// Description : Erases a boid's previous pixel and draws its current pixel in
//               the VGA framebuffer through one write port. Positions arrive
//               as signed 16.16 fixed point. The integer parts are latched on
//               start. Both pixel addresses and in-range flags are registered,
//               then the erase write is issued, then the draw write. The
//               framebuffer arbiter can hold a write off with mem_stall.
// Ports       : clk, reset (sync, active-high)
//               start            - request; sampled only when idle
//               x, y, px, py     - current / previous position, signed 16.16
//               mem_stall        - arbiter hold; write not accepted while high
//               busy, done       - status / one-cycle completion pulse
//               mem_we, mem_addr, mem_wdata - framebuffer write port
// Options     : BOID_PIXEL_SQUARE_EN - when defined, each erase/draw covers a
//               2x2 block (c,r),(c+1,r),(c,r+1),(c+1,r+1). Each sub-pixel is
//               range-checked on its own.
// Revision    : 1.0 - initial release
// ============================================================================
module boid_pixel_writer #(
  parameter int                 SCREEN_W    = 640,
  parameter int                 SCREEN_H    = 480,
  parameter int                 ADDR_W      = 19,
  parameter int                 COLOR_W     = 8,
  parameter logic [COLOR_W-1:0] DRAW_COLOR  = 8'hFF,
  parameter logic [COLOR_W-1:0] ERASE_COLOR = 8'h00
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [31:0]        x,
  input  logic [31:0]        y,
  input  logic [31:0]        px,
  input  logic [31:0]        py,
  input  logic               mem_stall,
  output logic               busy,
  output logic               done,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_wdata
);

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_LATCH = 3'd1;
  localparam logic [2:0] c_ST_ERASE = 3'd2;
  localparam logic [2:0] c_ST_DRAW  = 3'd3;
  localparam logic [2:0] c_ST_DONE  = 3'd4;

  logic [2:0] state_q, state_d;

  // Integer parts of the positions. Dropping the fraction of a signed value
  // floors it, so -0.5 becomes -1 and then fails the range check.
  logic signed [15:0] x_q, y_q, px_q, py_q;

  logic signed [31:0] w_c_new, w_r_new, w_c_old, w_r_old;
  logic        [31:0] w_old_full, w_new_full;

  logic [ADDR_W-1:0]  old_addr_q, new_addr_q;
  logic [ADDR_W-1:0]  last_addr_q;
  logic [COLOR_W-1:0] last_wdata_q;

  logic [ADDR_W-1:0]  w_off;
  logic               w_last_sub;
  logic               w_cur_ok;
  logic               w_step;

  assign w_c_new = {{16{x_q[15]}},  x_q};
  assign w_r_new = {{16{y_q[15]}},  y_q};
  assign w_c_old = {{16{px_q[15]}}, px_q};
  assign w_r_old = {{16{py_q[15]}}, py_q};

  function automatic logic in_range(input logic signed [31:0] c,
                                    input logic signed [31:0] r);
    return (c >= 0) && (c < SCREEN_W) && (r >= 0) && (r < SCREEN_H);
  endfunction

  // A 640-wide row is 512 + 128 words, so two shifts replace the multiplier.
  generate
    if (SCREEN_W == 640) begin : g_addr_shift
      assign w_old_full = (w_r_old <<< 9) + (w_r_old <<< 7) + w_c_old;
      assign w_new_full = (w_r_new <<< 9) + (w_r_new <<< 7) + w_c_new;
    end else begin : g_addr_mul
      assign w_old_full = w_r_old * SCREEN_W + w_c_old;
      assign w_new_full = w_r_new * SCREEN_W + w_c_new;
    end
  endgenerate

`ifdef BOID_PIXEL_SQUARE_EN
  logic [1:0] sub_q, sub_d;
  logic [3:0] old_ok_q, new_ok_q, w_old_ok, w_new_ok;

  // Bit i covers offset (i%2, i/2). That matches the emission order.
  always_comb begin
    w_old_ok = '0;
    w_new_ok = '0;
    for (int i = 0; i < 4; i++) begin
      w_old_ok[i] = in_range(w_c_old + (i % 2), w_r_old + (i / 2));
      w_new_ok[i] = in_range(w_c_new + (i % 2), w_r_new + (i / 2));
    end
  end

  assign w_last_sub = (sub_q == 2'd3);
  assign w_off      = (sub_q[1] ? ADDR_W'(SCREEN_W) : '0) + ADDR_W'(sub_q[0]);
  assign w_cur_ok   = (state_q == c_ST_DRAW) ? new_ok_q[sub_q] : old_ok_q[sub_q];

  // The counter wraps 3 -> 0 on the last sub-pixel. It is ready for the
  // next phase without an explicit clear.
  always_comb begin
    sub_d = sub_q;
    if (((state_q == c_ST_ERASE) || (state_q == c_ST_DRAW)) && w_step)
      sub_d = sub_q + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) sub_q <= 2'd0;
    else       sub_q <= sub_d;
  end
`else
  logic old_ok_q, new_ok_q, w_old_ok, w_new_ok;

  assign w_old_ok   = in_range(w_c_old, w_r_old);
  assign w_new_ok   = in_range(w_c_new, w_r_new);
  assign w_last_sub = 1'b1;
  assign w_off      = '0;
  assign w_cur_ok   = (state_q == c_ST_DRAW) ? new_ok_q : old_ok_q;
`endif

  // A skipped (out-of-range) pixel never waits on the arbiter.
  assign w_step = !w_cur_ok || !mem_stall;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= c_ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE:  if (start) state_d = c_ST_LATCH;
      c_ST_LATCH: state_d = c_ST_ERASE;
      c_ST_ERASE: if (w_step && w_last_sub) state_d = c_ST_DRAW;
      c_ST_DRAW:  if (w_step && w_last_sub) state_d = c_ST_DONE;
      c_ST_DONE:  state_d = c_ST_IDLE;
      default:    state_d = c_ST_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q          <= '0;
      y_q          <= '0;
      px_q         <= '0;
      py_q         <= '0;
      old_addr_q   <= '0;
      new_addr_q   <= '0;
      old_ok_q     <= '0;
      new_ok_q     <= '0;
      last_addr_q  <= '0;
      last_wdata_q <= '0;
    end else begin
      // Outside the write states the port shows whatever was last presented.
      last_addr_q  <= mem_addr;
      last_wdata_q <= mem_wdata;
      if ((state_q == c_ST_IDLE) && start) begin
        x_q  <= x[31:16];
        y_q  <= y[31:16];
        px_q <= px[31:16];
        py_q <= py[31:16];
      end
      if (state_q == c_ST_LATCH) begin
        old_addr_q <= w_old_full[ADDR_W-1:0];
        new_addr_q <= w_new_full[ADDR_W-1:0];
        old_ok_q   <= w_old_ok;
        new_ok_q   <= w_new_ok;
      end
    end
  end

  // Output logic
  always_comb begin
    busy      = (state_q != c_ST_IDLE);
    done      = (state_q == c_ST_DONE);
    mem_we    = 1'b0;
    mem_addr  = last_addr_q;
    mem_wdata = last_wdata_q;
    case (state_q)
      c_ST_ERASE: begin
        mem_we    = w_cur_ok;
        mem_addr  = old_addr_q + w_off;
        mem_wdata = ERASE_COLOR;
      end
      c_ST_DRAW: begin
        mem_we    = w_cur_ok;
        mem_addr  = new_addr_q + w_off;
        mem_wdata = DRAW_COLOR;
      end
      default: ;
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{x[15:0], y[15:0], px[15:0], py[15:0],
                         w_old_full[31:ADDR_W], w_new_full[31:ADDR_W]};

endmodule
`default_nettype wire

// File: tb/tb_boid_pixel_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_boid_pixel_writer
// Description : Self-checking bench for boid_pixel_writer. A list-based model
//               expands each request into an ordered list of write slots:
//               erase pixels, then draw pixels, each with an address, data
//               and an in-range flag. The model walks that list cycle by
//               cycle under a random or patterned mem_stall.
// Options     : BOID_PIXEL_SQUARE_EN - expand each pixel to a 2x2 block.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_boid_pixel_writer;

  localparam int W = 640;
  localparam int H = 480;
`ifdef BOID_PIXEL_SQUARE_EN
  localparam int SUBS = 4;
`else
  localparam int SUBS = 1;
`endif

  logic        clk = 1'b0;
  logic        reset, start, mem_stall;
  logic [31:0] x, y, px, py;
  logic        busy, done, mem_we;
  logic [18:0] mem_addr;
  logic [7:0]  mem_wdata;

  always #5 clk = ~clk;

  boid_pixel_writer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .x         (x),
    .y         (y),
    .px        (px),
    .py        (py),
    .mem_stall (mem_stall),
    .busy      (busy),
    .done      (done),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Model state
  bit          slot_ok[$];
  int          slot_addr[$];
  int          slot_data[$];
  int          last_addr;
  int          last_data;

  function automatic int ipart(input logic [31:0] v);
    return $signed(v) >>> 16;
  endfunction

  function automatic int pix(input int c, input int r);
    return (r * W + c) & 32'h7FFFF;
  endfunction

  task automatic build_slots(input logic [31:0] ix, iy, ipx, ipy);
    int c, r, cc, rr;
    slot_ok.delete(); slot_addr.delete(); slot_data.delete();
    for (int pass = 0; pass < 2; pass++) begin
      c = pass ? ipart(ix) : ipart(ipx);
      r = pass ? ipart(iy) : ipart(ipy);
      for (int s = 0; s < SUBS; s++) begin
        cc = c + (s % 2);
        rr = r + (s / 2);
        slot_ok.push_back(cc >= 0 && cc < W && rr >= 0 && rr < H);
        slot_addr.push_back(pix(cc, rr));
        slot_data.push_back(pass ? 8'hFF : 8'h00);
      end
    end
  endtask

  // One complete request. stall_pat bit n forces a stall in write cycle n.
  // Noise keeps start high and scrambles the inputs while the block is busy.
  task automatic run_op(input logic [31:0] ix, iy, ipx, ipy,
                        input int stall_pct, input logic [31:0] stall_pat,
                        input bit noise);
    int idx, cyc, writes, exp_writes, run;
    build_slots(ix, iy, ipx, ipy);
    exp_writes = 0;
    foreach (slot_ok[i]) if (slot_ok[i]) exp_writes++;
    x = ix; y = iy; px = ipx; py = ipy; start = 1'b1; mem_stall = 1'b0;
    @(posedge clk); #1;
    start = noise;
    if (noise) begin x = $urandom; y = $urandom; px = $urandom; py = $urandom; end
    @(negedge clk);
    check("latch_busy", busy, 1);
    check("latch_we", mem_we, 0);
    check("latch_done", done, 0);
    check("latch_addr_hold", mem_addr, last_addr);
    idx = 0; cyc = 0; writes = 0; run = 0;
    while (idx < slot_ok.size() && cyc < 200) begin
      @(posedge clk); #1;
      mem_stall = stall_pat[cyc % 32] || ($urandom_range(99) < stall_pct);
      if (run >= 6) mem_stall = 1'b0;
      start = noise;
      @(negedge clk);
      check("wr_we", mem_we, slot_ok[idx]);
      check("wr_addr", mem_addr, slot_addr[idx]);
      check("wr_data", mem_wdata, slot_data[idx]);
      check("wr_busy", busy, 1);
      check("wr_done", done, 0);
      last_addr = slot_addr[idx];
      last_data = slot_data[idx];
      if (slot_ok[idx] && mem_stall) run++;
      else begin
        run = 0;
        if (mem_we && !mem_stall) writes++;
        idx++;
      end
      cyc++;
    end
    @(posedge clk); #1;
    mem_stall = 1'b0;
    start = noise;
    @(negedge clk);
    check("done_pulse", done, 1);
    check("done_busy", busy, 1);
    check("done_we", mem_we, 0);
    check("done_addr_hold", mem_addr, last_addr);
    check("done_data_hold", mem_wdata, last_data);
    check("write_count", writes, exp_writes);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_we", mem_we, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ci, ri, pci, pri;
    reset = 1'b1; start = 1'b0; mem_stall = 1'b0;
    x = '0; y = '0; px = '0; py = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    reset = 1'b0;
    last_addr = 0; last_data = 0;

    // Basic move, no stall
    run_op(32'h00B4_0000, 32'h00F0_0000, 32'h00B0_0000, 32'h00EC_0000, 0, 32'h0, 1'b0);
    // Three stalled cycles on the first write
    run_op(32'h00B4_0000, 32'h00F0_0000, 32'h00B0_0000, 32'h00EC_0000, 0, 32'h7, 1'b0);
    // Off-screen previous pixel and right-edge current pixel
    run_op(32'h027F_8000, 32'h01DF_0000, 32'hFFFF_0000, 32'h01DF_0000, 0, 32'h0, 1'b0);
    // start held high while busy, with scrambled inputs
    run_op(32'h00B4_0000, 32'h00F0_0000, 32'h00B0_0000, 32'h00EC_0000, 0, 32'h0, 1'b1);
    // Same pixel for old and new
    run_op(32'h0010_4000, 32'h0020_0000, 32'h0010_0000, 32'h0020_C000, 0, 32'h2, 1'b0);
`ifdef BOID_PIXEL_SQUARE_EN
    run_op(32'h027F_0000, 32'h0000_0000, 32'h000A_0000, 32'h000A_0000, 0, 32'h0, 1'b0);
`endif

    // Reset while the draw write is presented
    x = 32'h00B4_0000; y = 32'h00F0_0000; px = 32'h00B0_0000; py = 32'h00EC_0000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (1 + SUBS) @(posedge clk);
    @(negedge clk);
    check("pre_rst_draw_we", mem_we, 1);
    check("pre_rst_draw_addr", mem_addr, 153780);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_we", mem_we, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_done", done, 0);
    check("post_rst_addr", mem_addr, 0);
    last_addr = 0; last_data = 0;
    run_op(32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 1'b0);

    // Random requests, mostly on-screen, sometimes just off any edge
    for (int n = 0; n < 150; n++) begin
      ci  = $urandom_range(W + 8) - 4;
      ri  = $urandom_range(H + 8) - 4;
      pci = ($urandom_range(3) == 0) ? ci : $urandom_range(W + 8) - 4;
      pri = ($urandom_range(3) == 0) ? ri : $urandom_range(H + 8) - 4;
      run_op({16'(ci), 16'($urandom)}, {16'(ri), 16'($urandom)},
             {16'(pci), 16'($urandom)}, {16'(pri), 16'($urandom)},
             $urandom_range(40), 32'h0, 1'($urandom_range(1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
